// File: rtl/input_prefetcher_pkg.sv
// Shared encodings for the input prefetcher: pass modes, FSM states and mode decode helpers.
package inpref_pkg;

    typedef enum logic [1:0] {
        MODE_S2     = 2'b00,
        MODE_S1     = 2'b01,
        MODE_CUT_S2 = 2'b10,
        MODE_CUT_S1 = 2'b11
    } inpref_mode_e;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN
    } inpref_state_e;

    function automatic logic mode_is_cut(input logic [1:0] mode);
        return mode[1];
    endfunction

    function automatic logic mode_is_s1(input logic [1:0] mode);
        return mode[0];
    endfunction

endpackage

// File: rtl/input_prefetcher_if.sv
// SRAM read port between the prefetcher (master) and the input feature SRAM (slave).
interface input_prefetcher_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 32
) ();
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;

    modport master (output rd_en, output rd_addr, input rd_data);
    modport slave  (input rd_en, input rd_addr, output rd_data);
endinterface

// File: rtl/input_prefetcher_skew.sv
// One PE row: a capture register followed by DEPTH skew stages; data is zeroed whenever invalid.
module skew_delay #(
    parameter int unsigned DW    = 8,
    parameter int unsigned DEPTH = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    output logic [DW-1:0] out_data
);
    logic [DEPTH:0] vld_q;
    logic [DW-1:0]  dat_q [DEPTH+1];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_q <= '0;
            for (int i = 0; i <= DEPTH; i++) dat_q[i] <= '0;
        end else begin
            vld_q[0] <= in_valid;
            dat_q[0] <= in_valid ? in_data : '0;
            for (int i = 1; i <= DEPTH; i++) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
            end
        end
    end

    assign out_valid = vld_q[DEPTH];
    assign out_data  = dat_q[DEPTH];
endmodule

// File: rtl/input_prefetcher.sv
// Fetches input-feature columns from SRAM and streams them row-skewed into the PE array,
// with stride 1/2 addressing and a cutting mode that replays the previous pass's last column.
module input_prefetcher
    import inpref_pkg::*;
#(
    parameter int unsigned DW     = 8,
    parameter int unsigned ROWS   = 4,
    parameter int unsigned IMG_W  = 8,
    parameter int unsigned ADDR_W = 10
) (
    input  logic                   clk,
    input  logic                   inpref_rst_n,
    input  logic                   in_en,
    input  logic [1:0]             inpref_mode_selector,
    input  logic [ADDR_W-1:0]      base_addr,
    input_prefetcher_if.master     sram,
    output logic [ROWS*DW-1:0]     pe_data,
    output logic [ROWS-1:0]        pe_valid,
    output logic                   busy,
    output logic                   done
);
    localparam int unsigned CNT_W = $clog2(IMG_W + 1);
    localparam int unsigned DRN_W = $clog2(ROWS + 1);

    inpref_state_e       state_q;
    logic                in_en_q;
    logic [CNT_W-1:0]    n_q;
    logic [CNT_W-1:0]    slot_cnt_q;
    logic [ADDR_W-1:0]   step_q;
    logic [ADDR_W-1:0]   ptr_q;
    logic [DRN_W-1:0]    drain_cnt_q;
    logic                rd_en_q;
    logic [ADDR_W-1:0]   rd_addr_q;
    // A slot is one column position: either an SRAM read or the replayed hold column.
    logic                slot_q;
    logic                slot_hold_q;
    logic                rvalid_q;
    logic                rhold_q;
    logic [ROWS*DW-1:0]  hold_col_q;
    logic [ROWS*DW-1:0]  col_in;

    logic                start;
    logic                start_cut;
    logic [ADDR_W-1:0]   start_step;
    logic [CNT_W-1:0]    start_n;

    assign start      = in_en && !in_en_q;
    assign start_cut  = mode_is_cut(inpref_mode_selector);
    assign start_step = mode_is_s1(inpref_mode_selector) ? ADDR_W'(1) : ADDR_W'(2);
    assign start_n    = mode_is_s1(inpref_mode_selector) ? CNT_W'(IMG_W) : CNT_W'(IMG_W / 2);

    assign col_in       = rhold_q ? hold_col_q : sram.rd_data;
    assign sram.rd_en   = rd_en_q;
    assign sram.rd_addr = rd_addr_q;

    always_ff @(posedge clk) begin
        if (!inpref_rst_n) begin
            state_q     <= IDLE;
            in_en_q     <= 1'b0;
            n_q         <= '0;
            slot_cnt_q  <= '0;
            step_q      <= '0;
            ptr_q       <= '0;
            drain_cnt_q <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            slot_q      <= 1'b0;
            slot_hold_q <= 1'b0;
            rvalid_q    <= 1'b0;
            rhold_q     <= 1'b0;
            hold_col_q  <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            in_en_q  <= in_en;
            rvalid_q <= slot_q;
            rhold_q  <= slot_hold_q;
            done     <= 1'b0;
            if (rvalid_q) hold_col_q <= col_in;

            unique case (state_q)
                IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        state_q     <= FETCH;
                        busy        <= 1'b1;
                        n_q         <= start_n;
                        step_q      <= start_step;
                        slot_cnt_q  <= CNT_W'(1);
                        slot_q      <= 1'b1;
                        slot_hold_q <= start_cut;
                        if (start_cut) begin
                            rd_en_q <= 1'b0;
                            ptr_q   <= base_addr;
                        end else begin
                            rd_en_q   <= 1'b1;
                            rd_addr_q <= base_addr;
                            ptr_q     <= base_addr + start_step;
                        end
                    end
                end
                FETCH: begin
                    if (in_en && slot_cnt_q != n_q) begin
                        slot_q      <= 1'b1;
                        slot_hold_q <= 1'b0;
                        rd_en_q     <= 1'b1;
                        rd_addr_q   <= ptr_q;
                        ptr_q       <= ptr_q + step_q;
                        slot_cnt_q  <= slot_cnt_q + CNT_W'(1);
                    end else begin
                        slot_q      <= 1'b0;
                        slot_hold_q <= 1'b0;
                        rd_en_q     <= 1'b0;
                        drain_cnt_q <= '0;
                        state_q     <= DRAIN;
                    end
                end
                DRAIN: begin
                    // Last slot was issued the edge before entry; it reaches row ROWS-1 ROWS edges later.
                    if (drain_cnt_q == DRN_W'(ROWS - 1)) begin
                        done    <= 1'b1;
                        state_q <= IDLE;
                    end else begin
                        drain_cnt_q <= drain_cnt_q + DRN_W'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        skew_delay #(
            .DW    (DW),
            .DEPTH (r)
        ) u_skew (
            .clk       (clk),
            .rst_n     (inpref_rst_n),
            .in_valid  (rvalid_q),
            .in_data   (col_in[r*DW +: DW]),
            .out_valid (pe_valid[r]),
            .out_data  (pe_data[r*DW +: DW])
        );
    end
endmodule

// File: tb/tb_input_prefetcher.sv
// Directed bench for input_prefetcher: SRAM model mem[a] = {4{a[7:0]}}, negedge event logger.
module tb_input_prefetcher;
    import inpref_pkg::*;

    logic       clk = 1'b0;
    logic       inpref_rst_n;
    logic       in_en;
    logic [1:0] mode_sel;
    logic [9:0] base_addr;
    logic [31:0] pe_data;
    logic [3:0]  pe_valid;
    logic        busy;
    logic        done;

    input_prefetcher_if #(.ADDR_W(10), .DATA_W(32)) sram ();

    input_prefetcher #(
        .DW(8), .ROWS(4), .IMG_W(8), .ADDR_W(10)
    ) dut (
        .clk                  (clk),
        .inpref_rst_n         (inpref_rst_n),
        .in_en                (in_en),
        .inpref_mode_selector (mode_sel),
        .base_addr            (base_addr),
        .sram                 (sram),
        .pe_data              (pe_data),
        .pe_valid             (pe_valid),
        .busy                 (busy),
        .done                 (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (sram.rd_en) sram.rd_data <= {4{sram.rd_addr[7:0]}};

    int n_tests = 0;
    int n_fail  = 0;
    int cyc = 0;
    int start_cyc = 0;
    int busy_at_start = 0;
    int gate_err = 0;
    int rd_cnt;
    int rd_addr_log [32];
    int rd_rel_log [32];
    int row_cnt [4];
    int row_first [4];
    int row_data [4][32];
    int done_cnt;
    int done_rel;

    always @(posedge clk) cyc <= cyc + 1;

    // Event log, sampled mid-cycle; rel = edges since the start edge E0.
    always @(negedge clk) begin
        int rel;
        rel = cyc - start_cyc - 1;
        if (sram.rd_en) begin
            if (rd_cnt < 32) begin
                rd_addr_log[rd_cnt] = int'(sram.rd_addr);
                rd_rel_log[rd_cnt]  = rel;
            end
            rd_cnt++;
        end
        for (int r = 0; r < 4; r++) begin
            if (pe_valid[r]) begin
                if (row_cnt[r] == 0) row_first[r] = rel;
                if (row_cnt[r] < 32) row_data[r][row_cnt[r]] = int'(pe_data[r*8 +: 8]);
                row_cnt[r]++;
            end else if (pe_data[r*8 +: 8] != 8'h00) begin
                gate_err++;
            end
        end
        if (done) begin
            done_cnt++;
            done_rel = rel;
        end
    end

    task automatic check_eq(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_log();
        rd_cnt   = 0;
        done_cnt = 0;
        done_rel = -1;
        for (int r = 0; r < 4; r++) begin
            row_cnt[r]   = 0;
            row_first[r] = -1;
        end
    endtask

    task automatic run_pass(input logic [1:0] mode, input logic [9:0] base, input int hi,
                            input int tail, input bit scramble);
        @(posedge clk); #1;
        clear_log();
        mode_sel  = mode;
        base_addr = base;
        start_cyc = cyc;
        in_en     = 1'b1;
        @(posedge clk); #1;
        busy_at_start = int'(busy);
        if (scramble) begin
            mode_sel  = MODE_S2;
            base_addr = 10'h3FF;
        end
        repeat (hi - 1) @(posedge clk);
        #1 in_en = 1'b0;
        repeat (tail) @(posedge clk);
    endtask

    task automatic check_rows(input string tag, input int ncols, input int first_rel,
                              input int first_val, input int step, input bit cut_first,
                              input int cut_val);
        for (int r = 0; r < 4; r++) begin
            check_eq($sformatf("%s_row%0d_cnt", tag, r), row_cnt[r], ncols);
            check_eq($sformatf("%s_row%0d_first", tag, r), row_first[r], first_rel + r);
            for (int i = 0; i < ncols && i < 32; i++) begin
                int exp;
                if (cut_first) exp = (i == 0) ? cut_val : ((first_val + (i - 1) * step) & 8'hFF);
                else           exp = (first_val + i * step) & 8'hFF;
                check_eq($sformatf("%s_row%0d_col%0d", tag, r, i), row_data[r][i], exp);
            end
        end
    endtask

    initial begin
        inpref_rst_n = 1'b0;
        in_en        = 1'b0;
        mode_sel     = MODE_S2;
        base_addr    = '0;
        clear_log();
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_rd_en", int'(sram.rd_en), 0);
        check_eq("rst_rd_addr", int'(sram.rd_addr), 0);
        check_eq("rst_pe_valid", int'(pe_valid), 0);
        check_eq("rst_pe_data", int'(pe_data), 0);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_done", int'(done), 0);
        inpref_rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Stride 1; mode/base scrambled after the start edge must be ignored.
        run_pass(MODE_S1, 10'h010, 10, 10, 1'b1);
        check_eq("t1_busy_start", busy_at_start, 1);
        check_eq("t1_rd_cnt", rd_cnt, 8);
        for (int i = 0; i < 8; i++) begin
            check_eq($sformatf("t1_rd_addr%0d", i), rd_addr_log[i], 'h10 + i);
            check_eq($sformatf("t1_rd_rel%0d", i), rd_rel_log[i], i);
        end
        check_rows("t1", 8, 2, 'h10, 1, 1'b0, 0);
        check_eq("t1_done_cnt", done_cnt, 1);
        check_eq("t1_done_rel", done_rel, 12);
        check_eq("t1_busy_end", int'(busy), 0);

        // Cutting stride 1: replays 0x17 from the previous pass.
        run_pass(MODE_CUT_S1, 10'h020, 10, 10, 1'b0);
        check_eq("t3_rd_cnt", rd_cnt, 7);
        for (int i = 0; i < 7; i++) begin
            check_eq($sformatf("t3_rd_addr%0d", i), rd_addr_log[i], 'h20 + i);
            check_eq($sformatf("t3_rd_rel%0d", i), rd_rel_log[i], i + 1);
        end
        check_rows("t3", 8, 2, 'h20, 1, 1'b1, 'h17);
        check_eq("t3_done_cnt", done_cnt, 1);
        check_eq("t3_done_rel", done_rel, 12);

        // Stride 2.
        run_pass(MODE_S2, 10'h010, 10, 10, 1'b0);
        check_eq("t2_rd_cnt", rd_cnt, 4);
        for (int i = 0; i < 4; i++)
            check_eq($sformatf("t2_rd_addr%0d", i), rd_addr_log[i], 'h10 + 2 * i);
        check_rows("t2", 4, 2, 'h10, 2, 1'b0, 0);
        check_eq("t2_done_cnt", done_cnt, 1);
        check_eq("t2_done_rel", done_rel, 8);

        // in_en dropped after three cycles.
        run_pass(MODE_S1, 10'h040, 3, 15, 1'b0);
        check_eq("t4_rd_cnt", rd_cnt, 3);
        check_rows("t4", 3, 2, 'h40, 1, 1'b0, 0);
        check_eq("t4_done_cnt", done_cnt, 1);
        check_eq("t4_done_rel", done_rel, 7);
        check_eq("t4_busy_end", int'(busy), 0);

        // Reset mid-FETCH.
        @(posedge clk); #1;
        clear_log();
        mode_sel  = MODE_S1;
        base_addr = 10'h050;
        start_cyc = cyc;
        in_en     = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        inpref_rst_n = 1'b0;
        in_en        = 1'b0;
        @(posedge clk); #1;
        check_eq("t5_rd_en", int'(sram.rd_en), 0);
        check_eq("t5_rd_addr", int'(sram.rd_addr), 0);
        check_eq("t5_pe_valid", int'(pe_valid), 0);
        check_eq("t5_pe_data", int'(pe_data), 0);
        check_eq("t5_busy", int'(busy), 0);
        check_eq("t5_done", int'(done), 0);
        inpref_rst_n = 1'b1;
        clear_log();
        repeat (10) @(posedge clk);
        check_eq("t5_quiet_rd", rd_cnt, 0);
        check_eq("t5_quiet_row0", row_cnt[0], 0);
        check_eq("t5_quiet_done", done_cnt, 0);
        // Cleared hold column shows up as a zero first column.
        run_pass(MODE_CUT_S1, 10'h060, 10, 10, 1'b0);
        check_eq("t5_rd_cnt", rd_cnt, 7);
        check_eq("t5_rd_addr0", rd_addr_log[0], 'h60);
        check_rows("t5", 8, 2, 'h60, 1, 1'b1, 0);
        check_eq("t5_done_cnt", done_cnt, 1);

        // in_en held high well past the pass, then restarted.
        run_pass(MODE_S1, 10'h070, 20, 10, 1'b0);
        check_eq("t6_rd_cnt", rd_cnt, 8);
        check_eq("t6_done_cnt", done_cnt, 1);
        check_eq("t6_row3_cnt", row_cnt[3], 8);
        run_pass(MODE_S1, 10'h078, 10, 10, 1'b0);
        check_eq("t6b_rd_cnt", rd_cnt, 8);
        check_eq("t6b_rd_addr0", rd_addr_log[0], 'h78);
        check_eq("t6b_done_cnt", done_cnt, 1);

        check_eq("gate_zero", gate_err, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
